// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : micro_sequencer
//  Purpose  : Next-state controller for the microprogrammed control unit.
//             Owns the current-state register that addresses the control
//             microstore and selects the next state from the mode fields of
//             the current microinstruction (decoder target, fetch, literal
//             jump, increment, conditional branch, conditional hold).
//             A hold watchdog aborts to the fetch state if a memory wait
//             never completes.
//  Options  : `define USEQ_RETURN_STACK_EN adds a STACK_DEPTH-entry return
//             stack for the CALL (6) and RET (7) modes. Without it both
//             modes behave as FETCH and stack_err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module micro_sequencer #(
  parameter int STATE_W      = 7,
  parameter int FETCH_STATE  = 0,
  parameter int HOLD_TIMEOUT = 16,
  parameter int STACK_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         ns_sel,
  input  logic               inv,
  input  logic [1:0]         cond_sel,
  input  logic [STATE_W-1:0] cr_addr,
  input  logic [STATE_W-1:0] enc_addr,
  input  logic               moc,
  input  logic [1:0]         cond_in,
  output logic [STATE_W-1:0] state,
  output logic               holding,
  output logic               timeout_err,
  output logic               stack_err
);

  // Hold counter only needs to reach HOLD_TIMEOUT-1; the abort clears it.
  localparam int HC_W = (HOLD_TIMEOUT > 2) ? $clog2(HOLD_TIMEOUT) : 1;

  localparam logic [STATE_W-1:0] FETCH_ADDR = STATE_W'(FETCH_STATE);
  localparam logic [HC_W-1:0]    HOLD_LAST  = HC_W'(HOLD_TIMEOUT - 1);

  // Next-state modes carried in the microinstruction.
  typedef enum logic [2:0] {
    NS_ENC   = 3'd0,
    NS_FETCH = 3'd1,
    NS_JUMP  = 3'd2,
    NS_INC   = 3'd3,
    NS_CBR   = 3'd4,
    NS_CHOLD = 3'd5,
    NS_CALL  = 3'd6,
    NS_RET   = 3'd7
  } ns_mode_t;

  ns_mode_t           mode;
  logic               cond_raw;
  logic               cond;
  logic [STATE_W-1:0] inc_addr;
  logic [STATE_W-1:0] mode_next;
  logic [STATE_W-1:0] next_state;
  logic               hold_now;
  logic               abort;
  logic               stack_err_next;
  logic [HC_W-1:0]    hold_cnt;

`ifdef USEQ_RETURN_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [STATE_W-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]    sp;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   top_idx;
  logic               push;
  logic               pop;
  logic               stack_full;
  logic               stack_empty;

  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);
  assign wr_idx      = IDX_W'(sp);
  assign top_idx     = IDX_W'(sp - SP_W'(1));
`endif

  assign mode     = ns_mode_t'(ns_sel);
  assign inc_addr = state + STATE_W'(1);

  // Condition select and optional inversion.
  always_comb begin
    cond_raw = 1'b1;
    case (cond_sel)
      2'd0:    cond_raw = moc;
      2'd1:    cond_raw = cond_in[0];
      2'd2:    cond_raw = cond_in[1];
      default: cond_raw = 1'b1;
    endcase
    cond = cond_raw ^ inv;
  end

  // Mode decode: candidate next state, hold indication and stack requests.
  always_comb begin
    mode_next      = FETCH_ADDR;
    hold_now       = 1'b0;
    stack_err_next = 1'b0;
`ifdef USEQ_RETURN_STACK_EN
    push           = 1'b0;
    pop            = 1'b0;
`endif
    case (mode)
      NS_ENC:   mode_next = enc_addr;
      NS_FETCH: mode_next = FETCH_ADDR;
      NS_JUMP:  mode_next = cr_addr;
      NS_INC:   mode_next = inc_addr;
      NS_CBR:   mode_next = cond ? cr_addr : inc_addr;
      NS_CHOLD: begin
        mode_next = cond ? inc_addr : state;
        hold_now  = ~cond;
      end
`ifdef USEQ_RETURN_STACK_EN
      NS_CALL: begin
        // A full stack still takes the jump; only the return address is lost.
        mode_next = cr_addr;
        if (stack_full) begin
          stack_err_next = 1'b1;
        end else begin
          push = 1'b1;
        end
      end
      NS_RET: begin
        if (stack_empty) begin
          mode_next      = FETCH_ADDR;
          stack_err_next = 1'b1;
        end else begin
          mode_next = stack_mem[top_idx];
          pop       = 1'b1;
        end
      end
`endif
      default:  mode_next = FETCH_ADDR;
    endcase
  end

  // Watchdog override: the last allowed hold cycle forces a return to fetch.
  always_comb begin
    abort      = hold_now && (hold_cnt == HOLD_LAST);
    next_state = abort ? FETCH_ADDR : mode_next;
  end

  assign holding = hold_now;

  // Current-state register and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH_ADDR;
      timeout_err <= 1'b0;
    end else begin
      state       <= next_state;
      timeout_err <= abort;
    end
  end

  // Consecutive-hold counter; cleared by any advancing cycle or by an abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (abort || !hold_now) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + HC_W'(1);
    end
  end

`ifdef USEQ_RETURN_STACK_EN
  // Stack pointer and error pulse; reset empties the stack.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      stack_err <= stack_err_next;
      if (push) begin
        sp <= sp + SP_W'(1);
      end else if (pop) begin
        sp <= sp - SP_W'(1);
      end
    end
  end

  // Return-address storage; contents above the pointer are don't-care.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[wr_idx] <= inc_addr;
    end
  end
`else
  // No return stack: modes 6/7 fall back to FETCH and never flag an error.
  logic unused_stack_err;
  assign unused_stack_err = stack_err_next;
  assign stack_err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_micro_sequencer
//  Purpose  : Directed self-checking bench for micro_sequencer: reset, all
//             next-state modes, condition selection, hold/watchdog timing
//             and, with USEQ_RETURN_STACK_EN, the return stack.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_micro_sequencer;

  logic       clk;
  logic       reset;
  logic [2:0] ns_sel;
  logic       inv;
  logic [1:0] cond_sel;
  logic [6:0] cr_addr;
  logic [6:0] enc_addr;
  logic       moc;
  logic [1:0] cond_in;
  logic [6:0] state;
  logic       holding;
  logic       timeout_err;
  logic       stack_err;

  int checks;
  int failures;

  micro_sequencer #(
    .STATE_W      (7),
    .FETCH_STATE  (0),
    .HOLD_TIMEOUT (16),
    .STACK_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ns_sel      (ns_sel),
    .inv         (inv),
    .cond_sel    (cond_sel),
    .cr_addr     (cr_addr),
    .enc_addr    (enc_addr),
    .moc         (moc),
    .cond_in     (cond_in),
    .state       (state),
    .holding     (holding),
    .timeout_err (timeout_err),
    .stack_err   (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply a mode and literal target, then clock once.
  task automatic step(input logic [2:0] ns, input logic [6:0] cr);
    ns_sel  = ns;
    cr_addr = cr;
    #1;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    ns_sel   = 3'd3;
    inv      = 1'b0;
    cond_sel = 2'd0;
    cr_addr  = 7'd0;
    enc_addr = 7'd0;
    moc      = 1'b0;
    cond_in  = 2'b00;

    // Reset held two cycles with INC requested: state stays at fetch.
    tick();
    check("reset_state_1", state, 0);
    check("reset_tmo", timeout_err, 0);
    check("reset_serr", stack_err, 0);
    tick();
    check("reset_state_2", state, 0);

    // Increment sequence after release.
    reset = 1'b0;
    tick();
    check("inc_1", state, 1);
    tick();
    check("inc_2", state, 2);
    tick();
    check("inc_3", state, 3);

    // Wrap from 127 to 0.
    step(3'd2, 7'd127);
    check("jump_127", state, 127);
    step(3'd3, 7'd0);
    check("inc_wrap", state, 0);

    // Decoder target and fetch.
    step(3'd2, 7'd1);
    check("jump_1", state, 1);
    enc_addr = 7'd6;
    step(3'd0, 7'd0);
    check("enc_6", state, 6);
    step(3'd1, 7'd0);
    check("fetch", state, 0);

    // Conditional hold on moc: three waits then advance.
    step(3'd2, 7'd5);
    ns_sel = 3'd5; cond_sel = 2'd0; inv = 1'b0; moc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("chold_holding", holding, 1);
      tick();
      check("chold_state", state, 5);
    end
    moc = 1'b1;
    #1;
    check("chold_release_holding", holding, 0);
    tick();
    check("chold_advance", state, 6);
    // Inverted condition holds while moc is high.
    inv = 1'b1;
    #1;
    check("chold_inv_holding", holding, 1);
    tick();
    check("chold_inv_state", state, 6);
    inv = 1'b0; moc = 1'b0;

    // Watchdog: 16 consecutive holds abort to fetch.
    step(3'd2, 7'd9);
    check("jump_9", state, 9);
    ns_sel = 3'd5;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("wd_wait_state", state, 9);
      check("wd_wait_tmo", timeout_err, 0);
    end
    #1;
    check("wd_abort_holding", holding, 1);
    tick();
    check("wd_abort_state", state, 0);
    check("wd_abort_tmo", timeout_err, 1);
    // Counter cleared by the abort: 15 more holds stay quiet, and moc on the
    // 16th (would-be abort) cycle advances instead.
    tick();
    check("wd_pulse_end", timeout_err, 0);
    check("wd_rehold_state", state, 0);
    for (int i = 2; i <= 15; i++) begin
      tick();
      check("wd_rehold_tmo", timeout_err, 0);
    end
    moc = 1'b1;
    #1;
    check("wd_race_holding", holding, 0);
    tick();
    check("wd_race_state", state, 1);
    check("wd_race_tmo", timeout_err, 0);
    moc = 1'b0;

    // Conditional branch on each condition source.
    cond_sel = 2'd1; cond_in = 2'b01;
    step(3'd4, 7'd10);
    check("cbr_taken", state, 10);
    cond_in = 2'b00;
    step(3'd4, 7'd10);
    check("cbr_not_taken", state, 11);
    cond_sel = 2'd3; inv = 1'b1;
    step(3'd4, 7'd40);
    check("cbr_const_inv", state, 12);
    cond_sel = 2'd2; inv = 1'b0; cond_in = 2'b10;
    step(3'd4, 7'd40);
    check("cbr_cond1", state, 40);
    cond_in = 2'b00;

`ifdef USEQ_RETURN_STACK_EN
    // Call/return pair.
    step(3'd2, 7'd8);
    step(3'd6, 7'd20);
    check("call_target", state, 20);
    check("call_serr", stack_err, 0);
    step(3'd7, 7'd0);
    check("ret_target", state, 9);
    // Five nested calls overflow on the fifth.
    for (int i = 1; i <= 4; i++) begin
      step(3'd6, 7'd30);
      check("nest_state", state, 30);
      check("nest_serr", stack_err, 0);
    end
    step(3'd6, 7'd30);
    check("overflow_state", state, 30);
    check("overflow_serr", stack_err, 1);
    // Unwind: first push was 10, the next three 31.
    for (int i = 1; i <= 3; i++) begin
      step(3'd7, 7'd0);
      check("unwind_state", state, 31);
      check("unwind_serr", stack_err, 0);
    end
    step(3'd7, 7'd0);
    check("unwind_last", state, 10);
    step(3'd7, 7'd0);
    check("underflow_state", state, 0);
    check("underflow_serr", stack_err, 1);
`else
    // Without the stack, CALL and RET behave as FETCH.
    step(3'd2, 7'd8);
    step(3'd6, 7'd20);
    check("call_as_fetch", state, 0);
    check("call_serr", stack_err, 0);
    step(3'd2, 7'd8);
    step(3'd7, 7'd20);
    check("ret_as_fetch", state, 0);
    check("ret_serr", stack_err, 0);
`endif

    // Reset dominates a pending jump.
    reset = 1'b1;
    step(3'd2, 7'd77);
    check("reset_dominates", state, 0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule
`default_nettype wire
